// File: rtl/afifo_fwft_reader_if.sv
// Bundles the async FIFO read-side handshake with the first-word-fall-through output stream.
// The reader takes the slave view; the FIFO/consumer side takes the master view.
interface afifo_fwft_reader_if #(
  parameter int WIDTH = 4
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_dat;
  logic [WIDTH-1:0] out_dat;
  logic             out_vld;
  logic             out_rdy;
  logic [1:0]       level;

  modport slave (
    input  fifo_empty,
    input  fifo_rd_dat,
    input  out_rdy,
    output fifo_rd_en,
    output out_dat,
    output out_vld,
    output level
  );

  modport master (
    output fifo_empty,
    output fifo_rd_dat,
    output out_rdy,
    input  fifo_rd_en,
    input  out_dat,
    input  out_vld,
    input  level
  );
endinterface

// File: rtl/afifo_fwft_reader.sv
// FWFT adapter for a registered-read FIFO: 2 cycles from empty falling to out_vld, 1 word/cycle.
// 3-entry skid buffer; out_rdy never reaches fifo_rd_en combinationally.
module afifo_fwft_reader #(
  parameter int WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  afifo_fwft_reader_if.slave  bus_io
);

  logic [WIDTH-1:0] mem_q [3];
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             pend_q, pend_d;
  logic             issue;
  logic             capture;
  logic             pop;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for the in-flight word so a read is only issued when it is sure to fit.
  always_comb begin
    issue   = !bus_io.fifo_empty && (({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3);
    capture = pend_q;
    pop     = (occ_q != 2'd0) && bus_io.out_rdy;
    pend_d  = issue;
    head_d  = pop ? wrap_inc(head_q) : head_q;
    tail_d  = capture ? wrap_inc(tail_q) : tail_q;
    occ_d   = occ_q + {1'b0, capture} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      occ_q  <= 2'd0;
      pend_q <= 1'b0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      pend_q <= pend_d;
      if (capture) mem_q[tail_q] <= bus_io.fifo_rd_dat;
    end
  end

  assign bus_io.fifo_rd_en = issue;
  assign bus_io.out_vld    = (occ_q != 2'd0);
  assign bus_io.out_dat    = mem_q[head_q];
  assign bus_io.level      = occ_q;

endmodule

// File: tb/tb_afifo_fwft_reader.sv
// Directed and randomized checks of afifo_fwft_reader against a queue-based FIFO and buffer model.
module tb_afifo_fwft_reader;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;

  afifo_fwft_reader_if #(.WIDTH(WIDTH)) bus ();

  afifo_fwft_reader #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: FIFO contents, words held by the reader, and the word in flight.
  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH-1:0] buf_q[$];
  logic             inflight;
  logic [WIDTH-1:0] inflight_w;
  int               n_pop;
  int               dut_reads;
  int               rdy_mode;   // 0: hold low, 1: hold high, 2: random
  int               push_pct;   // chance per cycle of trickling a random word into the FIFO
  int               trickle_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = buf_q.size();
    chk("out_vld", 32'(bus.out_vld), 32'(lvl != 0));
    chk("level", 32'(bus.level), 32'(lvl));
    chk("fifo_rd_en", 32'(bus.fifo_rd_en),
        32'((src_q.size() != 0) && (lvl + int'(inflight) < 3)));
    if (lvl != 0) chk("out_dat", 32'(bus.out_dat), 32'(buf_q[0]));
    chk("occ_pend_bound", 32'((int'(bus.level) + int'(inflight)) <= 3), 32'd1);
  endtask

  // One clock: sample before the edge, advance the model, drive at +1, check at +2.
  task automatic tick();
    logic fire;
    logic popv;
    if (bus.fifo_rd_en && !bus.fifo_empty) dut_reads++;
    fire = (src_q.size() != 0) && (buf_q.size() + int'(inflight) < 3);
    popv = (buf_q.size() != 0) && bus.out_rdy;
    @(posedge clk);
    if (popv) begin
      void'(buf_q.pop_front());
      n_pop++;
    end
    if (inflight) buf_q.push_back(inflight_w);
    inflight = fire;
    if (fire) inflight_w = src_q.pop_front();
    #1;
    if (trickle_left > 0 && $urandom_range(0, 99) < push_pct) begin
      src_q.push_back(WIDTH'($urandom));
      trickle_left--;
    end
    bus.fifo_rd_dat = inflight ? inflight_w : WIDTH'($urandom);
    bus.fifo_empty  = (src_q.size() == 0);
    bus.out_rdy     = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    #1;
    check_outputs();
  endtask

  task automatic load(input logic [WIDTH-1:0] w);
    src_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  initial begin
    int n;
    int base;

    rst_n = 1'b0;
    inflight = 1'b0;
    inflight_w = '0;
    n_pop = 0;
    dut_reads = 0;
    rdy_mode = 1;
    push_pct = 0;
    trickle_left = 0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_dat = '0;
    bus.out_rdy = 1'b1;

    // Reset state, held idle for 10 cycles after release.
    #3;
    chk("rst_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_dat", 32'(bus.out_dat), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) tick();

    // Single word: read at t, out_vld at t+2, one pop empties it.
    load(4'hA);
    #1;
    chk("single_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    n = 0;
    while (!bus.out_vld && n < 10) begin
      tick();
      n++;
    end
    chk("single_latency", 32'(n), 32'd2);
    chk("single_dat", 32'(bus.out_dat), 32'hA);
    for (int i = 0; i < 4; i++) tick();
    chk("single_level_end", 32'(bus.level), 32'd0);

    // Eight words with the consumer stalled: exactly three reads.
    rdy_mode = 0;
    bus.out_rdy = 1'b0;
    base = dut_reads;
    for (int i = 0; i < 8; i++) load(WIDTH'(i));
    #1;
    for (int i = 0; i < 8; i++) tick();
    chk("stall_reads", 32'(dut_reads - base), 32'd3);
    chk("stall_level", 32'(bus.level), 32'd3);
    chk("stall_dat", 32'(bus.out_dat), 32'd0);

    // Release the consumer: eight words drain in eight consecutive cycles.
    rdy_mode = 1;
    bus.out_rdy = 1'b1;
    base = n_pop;
    n = 0;
    while (n_pop - base < 8 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_cycles", 32'(n), 32'd8);
    tick();
    chk("drain_level", 32'(bus.level), 32'd0);

    // 64 random words trickled in, random consumer readiness.
    rdy_mode = 2;
    push_pct = 60;
    trickle_left = 64;
    base = n_pop;
    n = 0;
    while (n_pop - base < 64 && n < 3000) begin
      tick();
      n++;
    end
    chk("random_words_out", 32'(n_pop - base), 32'd64);

    // Asynchronous reset while two words are held and one is in flight.
    rdy_mode = 0;
    bus.out_rdy = 1'b0;
    push_pct = 0;
    for (int i = 0; i < 5; i++) load(WIDTH'($urandom));
    #1;
    n = 0;
    while (!(buf_q.size() == 2 && inflight) && n < 20) begin
      tick();
      n++;
    end
    chk("pre_rst_level", 32'(bus.level), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.out_vld), 32'd0);
    chk("mid_rst_level", 32'(bus.level), 32'd0);
    src_q.delete();
    buf_q.delete();
    inflight = 1'b0;
    bus.fifo_empty = 1'b1;
    #1;
    chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    rdy_mode = 1;
    bus.out_rdy = 1'b1;
    load(4'h3);
    load(4'hC);
    load(4'h5);
    #1;
    base = n_pop;
    n = 0;
    while (n_pop - base < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("post_rst_words", 32'(n_pop - base), 32'd3);
    tick();
    chk("post_rst_level", 32'(bus.level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/afifo_fwft_reader.md
Name: afifo_fwft_reader

Overview:
- Read-side consumer for the async FIFO, running in the FIFO's read clock domain.
- Converts the FIFO's registered-read interface into a first-word-fall-through valid/ready stream: empty flag in, read enable out, data one cycle after the read.
- Prefetches words into a 3-entry skid buffer so a consumer that always asserts ready gets one word per cycle, with no combinational path from outReady to fifoRdEn.

Parameters:
- WIDTH, 4, data word width; must match the FIFO's WIDTH.

Ports:
- clk  in  1  read-domain clock; same clock as the FIFO read side.
- rst  in  1  asynchronous active-low reset; same reset as the FIFO read side.
- fifoEmpty  in  1  FIFO empty flag, registered in the FIFO.
- fifoRdEn  out  1  FIFO read request; a read occurs at the edge where fifoRdEn=1 and fifoEmpty=0.
- fifoRdData  in  WIDTH  FIFO read data, valid the cycle after an accepted read.
- outData  out  WIDTH  head-of-buffer word.
- outValid  out  1  outData holds a valid word.
- outReady  in  1  consumer accepts outData at this edge when outValid=1.
- level  out  2  number of words held in the buffer (0..3).

Behaviour:
- State registers:
  - mem[0:2], WIDTH each.
  - head and tail, 2 bits each, wrap 2->0.
  - occ, 2 bits, 0..3.
  - pend, 1 bit: a read was accepted at the previous edge.
- Reset (rst=0, asynchronous): head=0, tail=0, occ=0, pend=0, outValid=0, level=0, fifoRdEn=0, outData=0. mem contents are don't-care.
- fifoRdEn = !fifoEmpty && (occ + pend < 3). It is combinational from registered state and fifoEmpty only; it never depends on outReady.
- issue = fifoRdEn (already qualified by !fifoEmpty). pend <= issue every edge.
- capture = pend. On capture: mem[tail] <= fifoRdData, tail <= tail+1 (mod 3). fifoRdData is ignored whenever pend=0.
- pop = outValid && outReady. On pop: head <= head+1 (mod 3).
- occ <= occ + capture - pop.
  - capture and pop in the same cycle: occ unchanged, head and tail both advance.
  - pop with occ=1 and capture together: the new word is the head next cycle; no bubble.
- outValid = (occ != 0). outData = mem[head]. level = occ.
- All three are combinational from registers.
- outData is held stable while outValid=1 and outReady=0.
- Latency:
  - First read issues at the first edge where fifoEmpty=0.
  - That word is captured at the next edge; outValid rises after it.
  - Total: 2 cycles from fifoEmpty falling to outValid.
- Throughput: with outReady held high and the FIFO non-empty, steady state is occ=1, pend=1, and one word transfers per cycle.
- Overflow cannot occur by construction (occ+pend ≤ 3). The bench asserts occ+pend never exceeds 3 and capture never happens with occ=3 and no pop.
- Underflow: pop requires outValid, so occ never goes below 0. outReady with outValid=0 has no effect.
- FIFO going empty mid-stream: fifoRdEn drops in the same cycle. The in-flight word (pend=1) is still captured. There are no spurious captures.
- Word order out equals FIFO read order. No words are duplicated or dropped.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO and this block must be reset together so pointers stay consistent.

Test Plan:
- Reset with fifoEmpty=1, outReady=1 -> outValid=0, level=0, fifoRdEn=0 for 10 cycles; no captures.
- FIFO holds a single word 0xA; fifoEmpty falls at cycle t -> fifoRdEn=1 at t; outValid=1 with outData=0xA from cycle t+2; one pop returns level to 0; fifoRdEn stays 0 once fifoEmpty=1.
- FIFO holds 8 words 0..7; outReady held at 0 -> exactly 3 reads issued; level=3; fifoRdEn=0 thereafter; outData stays 0 throughout.
- Continue the previous case with outReady=1 -> words 0..7 emerge in order. After the pipeline refills, one word per cycle with no gaps. level ends at 0.
- Random outReady (50%) with 64 random words through the FIFO -> output sequence matches the scoreboard exactly; the occ+pend≤3 assertion never fires.
- Assert rst low while level=2 and pend=1 -> outValid=0 and level=0 immediately (asynchronous); after release, normal operation resumes with a fresh FIFO.
